mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU in cycles.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  issue pulse from E stage; qualifies MDU_op.
REQ-006 SHALL have port MDU_op  input  4  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, NONE.
REQ-007 SHALL have port A  input  32  rs operand.
REQ-008 SHALL have port B  input  32  rt operand.
REQ-009 SHALL have port busy  output  1  multi-cycle operation in flight.
REQ-010 SHALL have port stall_req  output  1  busy OR (start AND MDU_op is MULT/MULTU/DIV/DIVU); drives the D-stage stall.
REQ-011 SHALL have port MDU_result  output  32  HI when MDU_op=MFHI, LO when MFLO, else 0; combinational.

Function
REQ-012 SHALL implement FSM states IDLE, MUL_RUN, DIV_RUN, and a cycle counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-013 SHALL leave IDLE for MUL_RUN (MULT/MULTU) or DIV_RUN (DIV/DIVU) on start=1, latching the operands and signedness at that edge.
REQ-014 SHALL hold busy=1 for exactly MULT_CYCLES / DIV_CYCLES cycles, beginning the cycle after the issuing edge.
REQ-015 SHALL write HI/LO at the edge where busy falls and return to IDLE at that same edge; HI/LO SHALL not change earlier.
REQ-016 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned; HI=product[63:32], LO=product[31:0].
REQ-017 SHALL compute DIV with signed truncation toward zero (LO=quotient, HI=remainder with the sign of A) and DIVU unsigned.
REQ-018 SHALL still run the full DIV_CYCLES on division by zero (B=0) but leave HI/LO unchanged.
REQ-019 SHALL, in IDLE, write A to HI on MTHI and A to LO on MTLO at the start edge, with zero latency and busy remaining 0.
REQ-020 SHALL ignore start while busy=1 (any op); the pipeline is already stalled by stall_req.
REQ-021 SHALL serve MFHI/MFLO from current HI/LO; while busy=1 the values are pre-operation (consumers are stalled).
REQ-022 SHALL treat MDU_op=NONE or any unlisted code with start=1 as a no-op.

Reset
REQ-023 SHALL, on reset=0 at a rising edge, force state=IDLE, counter=0, HI=0, LO=0, busy=0, aborting any in-flight operation with no HI/LO write.
REQ-024 SHALL let reset take priority over start in the same cycle.

Structure
REQ-025 SHALL place the MDU_op encodings (4-bit localparams MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MFHI, MDU_MFLO) in the shared constants package used by the control decoder.
REQ-026 SHALL implement as a single module with no sub-module; the product and quotient are computed behaviourally at issue and held in result registers.

Verification
REQ-027 SHALL cover: MULT A=0xFFFFFFFF, B=2 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-028 SHALL cover: DIV A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 -> LO=3, HI=1.
REQ-029 SHALL cover: MTHI A=0x12345678, then DIVU A=5, B=0 -> busy for 10 cycles, HI remains 0x12345678, LO unchanged; MFHI returns 0x12345678.
REQ-030 SHALL cover: MULT issued, second start (MTLO A=0xDEAD) in cycle 2 of busy -> second start ignored, LO equals the product only.
REQ-031 SHALL cover: reset=0 during cycle 3 of DIV -> next cycle busy=0, HI=LO=0, state IDLE; a new MULT issued after reset completes normally.
REQ-032 SHALL cover: stall_req=1 in the issue cycle of MULT and throughout busy, 0 in the cycle after completion; stall_req=0 for MTHI/MFLO in IDLE.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU constants: op encodings and controller state type.
// Used by the control decoder and the multiply/divide controller.
package mdu_ctrl_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN
  } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller with HI/LO registers.
// Results are computed at issue and committed when busy ends.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDU_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] MDU_result
);

  localparam int MAX_CYC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W =
    (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST =
    CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST =
    CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      hi, lo;
  logic [31:0]      res_hi, res_lo;
  logic             res_ok;

  logic op_mul, op_div, op_mthi, op_mtlo;
  logic issue_mul, issue_div;
  logic wr_hi, wr_lo, done;

  assign op_mul  = start &&
    (MDU_op == MDU_MULT || MDU_op == MDU_MULTU);
  assign op_div  = start &&
    (MDU_op == MDU_DIV || MDU_op == MDU_DIVU);
  assign op_mthi = start && (MDU_op == MDU_MTHI);
  assign op_mtlo = start && (MDU_op == MDU_MTLO);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    issue_mul = 1'b0;
    issue_div = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          op_mul: begin
            state_d   = MUL_RUN;
            cnt_d     = MUL_LAST;
            issue_mul = 1'b1;
          end
          op_div: begin
            state_d   = DIV_RUN;
            cnt_d     = DIV_LAST;
            issue_div = 1'b1;
          end
          op_mthi: wr_hi = 1'b1;
          op_mtlo: wr_lo = 1'b1;
          default: ;
        endcase
      end
      MUL_RUN, DIV_RUN: begin
        if (cnt == '0) begin
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic        sgn;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div;
  logic [31:0] uq, ur, quot, rem;

  assign sgn   = (MDU_op == MDU_MULT) ||
                 (MDU_op == MDU_DIV);
  assign a_ext = {{32{sgn & A[31]}}, A};
  assign b_ext = {{32{sgn & B[31]}}, B};
  assign prod  = a_ext * b_ext;

  // Divide magnitudes, then fix signs: truncation toward zero
  // and -2^31 / -1 wraps cleanly to 0x80000000.
  assign a_neg = sgn & A[31];
  assign b_neg = sgn & B[31];
  assign a_mag = a_neg ? (~A + 32'd1) : A;
  assign b_mag = b_neg ? (~B + 32'd1) : B;
  assign b_div = (B == 32'd0) ? 32'd1 : b_mag;
  assign uq    = a_mag / b_div;
  assign ur    = a_mag % b_div;
  assign quot  = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
  assign rem   = a_neg ? (~ur + 32'd1) : ur;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_ok <= 1'b0;
    end else begin
      if (issue_mul) begin
        res_hi <= prod[63:32];
        res_lo <= prod[31:0];
        res_ok <= 1'b1;
      end
      if (issue_div) begin
        res_hi <= rem;
        res_lo <= quot;
        res_ok <= (B != 32'd0);
      end
      if (done && res_ok) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (wr_hi) hi <= A;
      if (wr_lo) lo <= A;
    end
  end

  assign busy      = (state != IDLE);
  assign stall_req = busy | op_mul | op_div;

  always_comb begin
    MDU_result = '0;
    if (MDU_op == MDU_MFHI) MDU_result = hi;
    else if (MDU_op == MDU_MFLO) MDU_result = lo;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: driver pushes expected outputs
// per cycle from a reference model, monitor pops at negedge.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  MDU_op;
  logic [31:0] A, B;
  logic        busy, stall_req;
  logic [31:0] MDU_result;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .MDU_op(MDU_op),
    .A(A),
    .B(B),
    .busy(busy),
    .stall_req(stall_req),
    .MDU_result(MDU_result)
  );

  typedef struct {
    int          tag;
    logic [31:0] res;
    logic        bsy;
    logic        stl;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int checks = 0;
  int failures = 0;

  logic [31:0] m_hi = 0, m_lo = 0;
  logic [31:0] p_hi = 0, p_lo = 0;
  int          m_left = 0;
  bit          m_pend = 0;

  function automatic bit is_md(input logic [3:0] op);
    return op == 4'd1 || op == 4'd2 ||
           op == 4'd3 || op == 4'd4;
  endfunction

  task automatic model_edge(input bit rn, input bit st,
      input logic [3:0] op, input logic [31:0] a,
      input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, u;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (!rn) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_pend = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pend) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (st) begin
      case (op)
        MDU_MULT: begin
          sq = sa * sb;
          {p_hi, p_lo} = sq;
          m_pend = 1; m_left = MC;
        end
        MDU_MULTU: begin
          u = ua * ub;
          {p_hi, p_lo} = u;
          m_pend = 1; m_left = MC;
        end
        MDU_DIV: begin
          m_pend = (b != 0); m_left = DC;
          if (b != 0) begin
            sq = sa / sb;
            sr = sa % sb;
            p_lo = sq[31:0];
            p_hi = sr[31:0];
          end
        end
        MDU_DIVU: begin
          m_pend = (b != 0); m_left = DC;
          if (b != 0) begin
            u = ua / ub;
            p_lo = u[31:0];
            u = ua % ub;
            p_hi = u[31:0];
          end
        end
        MDU_MTHI: m_hi = a;
        MDU_MTLO: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input bit rn, input bit st,
      input logic [3:0] op, input logic [31:0] a,
      input logic [31:0] b, input int tag,
      input bit use_res, input logic [31:0] res);
    exp_t e;
    reset = rn; start = st; MDU_op = op; A = a; B = b;
    e.tag = tag;
    e.bsy = (m_left > 0);
    e.stl = e.bsy || (st && is_md(op));
    if (use_res) e.res = res;
    else if (op == MDU_MFHI) e.res = m_hi;
    else if (op == MDU_MFLO) e.res = m_lo;
    else e.res = 32'd0;
    q.push_back(e);
    @(posedge clk);
    model_edge(rn, st, op, a, b);
    #1;
  endtask

  task automatic issue(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input int tag);
    cyc(1, 1, op, a, b, tag, 0, 0);
  endtask

  task automatic idle(input int tag);
    cyc(1, 0, MDU_NONE, 0, 0, tag, 0, 0);
  endtask

  task automatic wait_idle(input int tag);
    while (m_left > 0) idle(tag);
  endtask

  task automatic rd(input logic [3:0] op,
      input logic [31:0] v, input int tag);
    cyc(1, 0, op, 0, 0, tag, 1, v);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      checks += 3;
      if (MDU_result !== me.res) begin
        failures++;
        $display("FAIL result tag=%0d got=%h exp=%h",
                 me.tag, MDU_result, me.res);
      end
      if (busy !== me.bsy) begin
        failures++;
        $display("FAIL busy tag=%0d got=%b exp=%b",
                 me.tag, busy, me.bsy);
      end
      if (stall_req !== me.stl) begin
        failures++;
        $display("FAIL stall tag=%0d got=%b exp=%b",
                 me.tag, stall_req, me.stl);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit rn, st;
    logic [3:0] op;
    reset = 0; start = 0; MDU_op = 0; A = 0; B = 0;
    @(posedge clk);
    #1;
    cyc(0, 0, MDU_NONE, 0, 0, 1, 0, 0);
    cyc(0, 1, MDU_MULT, 3, 3, 2, 0, 0);
    rd(MDU_MFHI, 32'h0, 3);
    rd(MDU_MFLO, 32'h0, 4);

    issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2, 10);
    rd(MDU_MFHI, 32'h0, 11);
    wait_idle(12);
    rd(MDU_MFHI, 32'hFFFF_FFFF, 13);
    rd(MDU_MFLO, 32'hFFFF_FFFE, 14);

    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 20);
    wait_idle(21);
    rd(MDU_MFHI, 32'h0000_0001, 22);
    rd(MDU_MFLO, 32'hFFFF_FFFE, 23);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 30);
    rd(MDU_MFLO, 32'hFFFF_FFFE, 31);
    wait_idle(32);
    rd(MDU_MFLO, 32'hFFFF_FFFD, 33);
    rd(MDU_MFHI, 32'hFFFF_FFFF, 34);
    issue(MDU_DIVU, 32'd7, 32'd2, 35);
    wait_idle(36);
    rd(MDU_MFLO, 32'd3, 37);
    rd(MDU_MFHI, 32'd1, 38);

    issue(MDU_MTHI, 32'h1234_5678, 0, 40);
    rd(MDU_MFHI, 32'h1234_5678, 41);
    issue(MDU_DIVU, 32'd5, 32'd0, 42);
    wait_idle(43);
    rd(MDU_MFHI, 32'h1234_5678, 44);
    rd(MDU_MFLO, 32'd3, 45);
    cyc(1, 1, MDU_MFLO, 0, 0, 46, 1, 32'd3);

    issue(MDU_MULT, 32'd3, 32'd4, 50);
    idle(51);
    issue(MDU_MTLO, 32'h0000_DEAD, 0, 52);
    wait_idle(53);
    rd(MDU_MFLO, 32'd12, 54);
    rd(MDU_MFHI, 32'd0, 55);

    issue(MDU_DIV, 32'd100, 32'd7, 60);
    idle(61);
    idle(62);
    cyc(0, 1, MDU_MULT, 9, 9, 63, 0, 0);
    rd(MDU_MFHI, 32'd0, 64);
    rd(MDU_MFLO, 32'd0, 65);
    issue(MDU_MULT, 32'd6, 32'd7, 66);
    wait_idle(67);
    rd(MDU_MFLO, 32'd42, 68);
    rd(MDU_MFHI, 32'd0, 69);

    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 70);
    wait_idle(71);
    rd(MDU_MFLO, 32'h8000_0000, 72);
    rd(MDU_MFHI, 32'd0, 73);

    for (int i = 0; i < 2500; i++) begin
      rn = ($urandom_range(0, 199) != 0);
      st = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      cyc(rn, st, op, pick(), pick(), 1000, 0, 0);
    end
    wait_idle(1001);
    rd(MDU_MFHI, m_hi, 1002);
    rd(MDU_MFLO, m_lo, 1003);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
